// File: rtl/csi_pkg.sv
// -----------------------------------------------------------------------------
// csi_pkg
// Shared constants and types for the CSI-2 receive path.
//   RAW10_GROUP_BYTES : bytes per RAW10 packing group (4 MSB bytes + 1 LSB byte)
//   RAW10_GROUP_PIX   : pixels carried by one group
//   PIX_WIDTH         : bits per RAW10 pixel
//   state_t           : line framing state of the unpacker
// -----------------------------------------------------------------------------
package csi_pkg;

    localparam int RAW10_GROUP_BYTES = 5;
    localparam int RAW10_GROUP_PIX   = 4;
    localparam int PIX_WIDTH         = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/raw10_group_decode.sv
// -----------------------------------------------------------------------------
// raw10_group_decode
// Combinational RAW10 group decoder. Byte 4 of the group carries the two
// LSBs of each pixel; pixel i takes its 8 MSBs from byte i and its 2 LSBs
// from bits [2i+1:2i] of byte 4.
// Ports:
//   group_bytes : in,  5 packed bytes, byte 0 at [7:0]
//   pixels      : out, 4 x 10-bit pixels, P0 at [9:0], P3 at [39:30]
// -----------------------------------------------------------------------------
module raw10_group_decode
    import csi_pkg::*;
(
    input  logic [8*RAW10_GROUP_BYTES-1:0]       group_bytes,
    output logic [RAW10_GROUP_PIX*PIX_WIDTH-1:0] pixels
);

    localparam int LSB_BYTE = RAW10_GROUP_BYTES - 1;

    always_comb begin
        pixels = '0;
        for (int i = 0; i < RAW10_GROUP_PIX; i++) begin
            pixels[PIX_WIDTH*i +: PIX_WIDTH] = {group_bytes[8*i +: 8],
                                                group_bytes[8*LSB_BYTE + 2*i +: 2]};
        end
    end

endmodule

// File: rtl/raw10_unpacker.sv
// -----------------------------------------------------------------------------
// raw10_unpacker
// Unpacks byte-aligned CSI-2 RAW10 payload beats into groups of four 10-bit
// pixels. Partial 5-byte groups are carried across beats in an 8-byte buffer.
// At most one group is consumed per beat, which keeps the byte count in the
// sequence 0->4->3->2->1->0 so the buffer can never overflow.
//
// Build option: define RAW10_LINE_CNT_EN to build the saturating per-line
// pixel counter and the line_pixels register; otherwise line_pixels is 0.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   aligned_data   : in,  32-bit payload beat, byte 0 at [7:0]
//   aligned_valid  : in,  beat valid
//   end_of_packet  : in,  last beat of the line (qualified by aligned_valid)
//   pixel_data     : out, P0 at [9:0] .. P3 at [39:30]
//   pixel_valid    : out, pixel_data holds a new group
//   line_end       : out, one-cycle pulse after the eop beat
//   line_err       : out, one-cycle pulse, packet length not a multiple of 5
//   line_pixels    : out, pixel count of the last closed line
// -----------------------------------------------------------------------------
module raw10_unpacker
    import csi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] aligned_data,
    input  logic                  aligned_valid,
    input  logic                  end_of_packet,
    output logic [39:0]           pixel_data,
    output logic                  pixel_valid,
    output logic                  line_end,
    output logic                  line_err,
    output logic [CNT_WIDTH-1:0]  line_pixels
);

    localparam int GRP_W = 8 * RAW10_GROUP_BYTES;
    localparam int BUF_W = 64;

    logic [BUF_W-1:0] buf_p0;
    logic [3:0]       cnt_p0;
    state_t           state_p0;

    logic [6:0]       sh;
    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] merged;
    logic [BUF_W-1:0] rem_buf;
    logic [3:0]       total;
    logic [3:0]       rem_cnt;
    logic             take_grp;
    logic [39:0]      dec_pix;

    // Stage 0: append the beat above the buffered bytes and peel off one group.
    // Bytes at or above cnt are masked, so the data buffer needs no reset.
    always_comb begin
        sh        = {cnt_p0, 3'b000};
        keep_mask = ~({BUF_W{1'b1}} << sh);
        merged    = (buf_p0 & keep_mask)
                  | ({{(BUF_W-DATA_WIDTH){1'b0}}, aligned_data} << sh);
        total     = cnt_p0 + 4'd4;
        take_grp  = (total >= 4'(RAW10_GROUP_BYTES));
        if (take_grp) begin
            rem_cnt = total - 4'(RAW10_GROUP_BYTES);
            rem_buf = merged >> GRP_W;
        end else begin
            rem_cnt = total;
            rem_buf = merged;
        end
    end

    raw10_group_decode u_decode (
        .group_bytes (merged[GRP_W-1:0]),
        .pixels      (dec_pix)
    );

    always_ff @(posedge clk) begin
        if (aligned_valid) begin
            buf_p0 <= rem_buf;
        end
    end

    // Stage 1: registered outputs and framing control.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0      <= '0;
            state_p0    <= IDLE;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            line_end    <= 1'b0;
            line_err    <= 1'b0;
        end else begin
            pixel_valid <= aligned_valid && take_grp;
            line_end    <= aligned_valid && end_of_packet;
            line_err    <= aligned_valid && end_of_packet && (rem_cnt != 4'd0);
            if (aligned_valid) begin
                if (take_grp) begin
                    pixel_data <= dec_pix;
                end
                // Residue left at end of packet is dropped.
                cnt_p0 <= end_of_packet ? 4'd0 : rem_cnt;
                case (state_p0)
                    IDLE:    if (!end_of_packet) state_p0 <= ACTIVE;
                    ACTIVE:  if (end_of_packet)  state_p0 <= IDLE;
                    default: state_p0 <= IDLE;
                endcase
            end
        end
    end

`ifdef RAW10_LINE_CNT_EN
    logic [CNT_WIDTH-1:0] pix_cnt_p0;
    logic [CNT_WIDTH-1:0] pix_cnt_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_add_grp(input logic [CNT_WIDTH-1:0] a);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH+1)'(RAW10_GROUP_PIX);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    always_comb begin
        pix_cnt_nxt = take_grp ? sat_add_grp(pix_cnt_p0) : pix_cnt_p0;
    end

    // Stage 1: line pixel count, includes the group closed by the eop beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_p0  <= '0;
            line_pixels <= '0;
        end else if (aligned_valid) begin
            if (end_of_packet) begin
                line_pixels <= pix_cnt_nxt;
                pix_cnt_p0  <= '0;
            end else begin
                pix_cnt_p0  <= pix_cnt_nxt;
            end
        end
    end
`else
    assign line_pixels = '0;
`endif

endmodule

// File: tb/tb_raw10_unpacker.sv
// -----------------------------------------------------------------------------
// tb_raw10_unpacker
// Directed bench for raw10_unpacker. Expected pixels are hand-decoded from
// the byte stream 80 40 20 10 E4 | 01 02 03 04 FF | FF 00 AA 55 00 |
// 12 34 56 78 1B. Expected line_pixels follows RAW10_LINE_CNT_EN.
// -----------------------------------------------------------------------------
module tb_raw10_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aligned_data;
    logic        aligned_valid;
    logic        end_of_packet;
    logic [39:0] pixel_data;
    logic        pixel_valid;
    logic        line_end;
    logic        line_err;
    logic [15:0] line_pixels;

    raw10_unpacker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .aligned_data  (aligned_data),
        .aligned_valid (aligned_valid),
        .end_of_packet (end_of_packet),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .line_end      (line_end),
        .line_err      (line_err),
        .line_pixels   (line_pixels)
    );

    always #5 clk = ~clk;

`ifdef RAW10_LINE_CNT_EN
    localparam logic [15:0] LP4  = 16'd4;
    localparam logic [15:0] LP16 = 16'd16;
`else
    localparam logic [15:0] LP4  = 16'd0;
    localparam logic [15:0] LP16 = 16'd0;
`endif

    typedef struct packed {
        logic        le;
        logic        err;
        logic        pv;
        logic [15:0] lp;
    } end_t;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] pix_q[$];
    end_t        end_q[$];
    logic [31:0] pv_hist = '0;

    logic [31:0] line_beats [5] = '{32'h10204080, 32'h030201E4, 32'h00FFFF04,
                                    32'h120055AA, 32'h1B785634};
    logic [39:0] line_pix [4] = '{
        {10'h043, 10'h082, 10'h101, 10'h200},
        {10'h013, 10'h00F, 10'h00B, 10'h007},
        {10'h154, 10'h2A8, 10'h000, 10'h3FC},
        {10'h1E0, 10'h159, 10'h0D2, 10'h04B}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        pv_hist = {pv_hist[30:0], pixel_valid};
        if (pixel_valid) pix_q.push_back(pixel_data);
        if (line_end || line_err) end_q.push_back({line_end, line_err, pixel_valid, line_pixels});
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic beat(input logic [31:0] d, input logic eop);
        aligned_data  = d;
        aligned_valid = 1'b1;
        end_of_packet = eop;
        step();
        aligned_valid = 1'b0;
        end_of_packet = 1'b0;
        aligned_data  = '0;
    endtask

    task automatic send_line(input int gap);
        for (int i = 0; i < 5; i++) begin
            beat(line_beats[i], i == 4);
            if (gap > 0 && i < 4) idle(gap);
        end
    endtask

    task automatic clear_q();
        pix_q.delete();
        end_q.delete();
    endtask

    task automatic check_lines(input string tag, input int lines);
        chk({tag, "_ngrp"}, pix_q.size(), 4 * lines);
        for (int i = 0; i < pix_q.size() && i < 4 * lines; i++)
            chk($sformatf("%s_pix%0d", tag, i), pix_q[i], line_pix[i % 4]);
        chk({tag, "_nend"}, end_q.size(), lines);
        for (int i = 0; i < end_q.size() && i < lines; i++) begin
            chk($sformatf("%s_le%0d", tag, i),  end_q[i].le,  1);
            chk($sformatf("%s_err%0d", tag, i), end_q[i].err, 0);
            chk($sformatf("%s_pv%0d", tag, i),  end_q[i].pv,  1);
            chk($sformatf("%s_lp%0d", tag, i),  end_q[i].lp,  LP16);
        end
        clear_q();
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_pd"}, pixel_data,  0);
        chk({tag, "_pv"}, pixel_valid, 0);
        chk({tag, "_le"}, line_end,    0);
        chk({tag, "_er"}, line_err,    0);
        chk({tag, "_lp"}, line_pixels, 0);
    endtask

    initial begin
        rst           = 1'b1;
        aligned_data  = '0;
        aligned_valid = 1'b0;
        end_of_packet = 1'b0;
        idle(3);
        check_reset_outs("rst");
        rst = 1'b0;
        idle(2);
        clear_q();

        // Single group with 3-byte residue.
        beat(32'h10204080, 1'b0);
        beat(32'h000000E4, 1'b1);
        idle(2);
        chk("sg_ngrp", pix_q.size(), 1);
        if (pix_q.size() > 0) chk("sg_pix", pix_q[0], {10'h043, 10'h082, 10'h101, 10'h200});
        chk("sg_nend", end_q.size(), 1);
        if (end_q.size() > 0) begin
            chk("sg_le",  end_q[0].le,  1);
            chk("sg_err", end_q[0].err, 1);
            chk("sg_pv",  end_q[0].pv,  1);
            chk("sg_lp",  end_q[0].lp,  LP4);
        end
        clear_q();

        // Single-beat line from IDLE: no group, residue 4.
        beat(32'hDEADBEEF, 1'b1);
        idle(1);
        chk("sb_ngrp", pix_q.size(), 0);
        chk("sb_nend", end_q.size(), 1);
        if (end_q.size() > 0) begin
            chk("sb_le",  end_q[0].le,  1);
            chk("sb_err", end_q[0].err, 1);
            chk("sb_pv",  end_q[0].pv,  0);
            chk("sb_lp",  end_q[0].lp,  0);
        end
        clear_q();

        // Clean line, with cycle positions of the groups.
        send_line(0);
        idle(2);
        chk("cl_timing", pv_hist[6:0], 7'b0111100);
        check_lines("cl", 1);

        // Gapped line.
        send_line(2);
        idle(2);
        check_lines("gap", 1);

        // Back-to-back lines.
        send_line(0);
        send_line(0);
        idle(2);
        check_lines("b2b", 2);

        // Reset mid-line.
        beat(line_beats[0], 1'b0);
        beat(line_beats[1], 1'b0);
        beat(line_beats[2], 1'b0);
        rst = 1'b1;
        step();
        check_reset_outs("mid_rst");
        rst = 1'b0;
        idle(2);
        chk("abort_nend", end_q.size(), 0);
        clear_q();
        send_line(0);
        idle(2);
        check_lines("post_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
